// File: rtl/fdce_bank_sequencer.sv
// fdce_bank_sequencer
// Walks a bank of FDCE flops one at a time through clear / load / hold
// exercises. Each response is checked one cycle after the stimulus, and the
// mismatches are summarised as a count, the first failing index and a pass flag.
module fdce_bank_sequencer #(
    parameter int N_FF  = 8,
    parameter int ERR_W = 8,
    localparam int IDX_W = (N_FF > 1) ? $clog2(N_FF) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_FF-1:0]     ff_ce,
    output logic [N_FF-1:0]     ff_clr,
    output logic [N_FF-1:0]     ff_d,
    input  logic [N_FF-1:0]     ff_q,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [IDX_W-1:0]    first_err_idx,
    output logic                first_err_valid
);

    typedef enum logic [2:0] {
        IDLE, CLR, CHK0, LD, CHK1, HOLD, CHKH, DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FF - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [N_FF-1:0]   sel;
    logic              in_pass;
    logic              is_chk;
    logic              expect_q;
    logic              mismatch;
    logic              last;
    logic              accept;
    logic              aborting;

    // One-hot select of the flop under test; a shift keeps the index width
    // independent of N_FF.
    assign sel      = N_FF'(1) << idx;
    assign in_pass  = state inside {CLR, CHK0, LD, CHK1, HOLD, CHKH};
    assign is_chk   = state inside {CHK0, CHK1, CHKH};
    // CHK0 follows the clear, so the flop must read 0; the other checks follow a load of 1.
    assign expect_q = (state != CHK0);
    assign mismatch = is_chk && ((|(ff_q & sel)) != expect_q);
    assign last     = (idx == LAST_IDX);
    // Abort beats start in IDLE, so a combined request never begins a pass.
    assign accept   = (state == IDLE) && start && !abort;
    assign aborting = in_pass && abort;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: abort exits from any active state; otherwise the
    // states advance one per cycle.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        if (aborting) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = CLR;
                CLR:     state_next = CHK0;
                CHK0:    state_next = LD;
                LD:      state_next = CHK1;
                CHK1:    state_next = HOLD;
                HOLD:    state_next = CHKH;
                CHKH:    state_next = last ? DONE : CLR;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Moore output decode of the registered state and index.
    always_comb begin
        ff_ce  = '0;
        ff_clr = '0;
        ff_d   = '0;
        done   = 1'b0;
        busy   = in_pass;
        case (state)
            CLR:     ff_clr = sel;
            LD: begin
                ff_ce = sel;
                ff_d  = sel;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: index walk, error accounting and the pass verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else if (aborting) begin
            // The error count and first-error record survive an abort.
            idx  <= '0;
            pass <= 1'b0;
        end else begin
            if (accept) begin
                idx             <= '0;
                err_count       <= '0;
                pass            <= 1'b0;
                first_err_idx   <= '0;
                first_err_valid <= 1'b0;
            end
            if (mismatch) begin
                if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
                if (!first_err_valid) begin
                    first_err_idx   <= idx;
                    first_err_valid <= 1'b1;
                end
            end
            if (state == CHKH) begin
                if (last) pass <= (err_count == '0) && !mismatch;
                else      idx  <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fdce_bank_sequencer.sv
// tb_fdce_bank_sequencer
// Three sequencer instances (8 flops/8-bit count, 2 flops/2-bit count, 1 flop)
// each drive a behavioural FDCE bank with selectable faults. Expected results
// come from per-flop response patterns; the drive schedule comes from the
// 6-cycles-per-flop timetable.
module tb_fdce_bank_sequencer;

    localparam int NA = 8, EA = 8;
    localparam int NB = 2, EB = 2;
    localparam int NC = 1, EC = 8;

    logic clk = 1'b0;
    logic rst, start, abort;

    logic [NA-1:0] ce_a, clr_a, d_a;
    logic [NA-1:0] q_a = '0;
    logic          busy_a, done_a, pass_a, fval_a;
    logic [EA-1:0] err_a;
    logic [2:0]    fidx_a;

    logic [NB-1:0] ce_b, clr_b, d_b;
    logic [NB-1:0] q_b = '0;
    logic          busy_b, done_b, pass_b, fval_b;
    logic [EB-1:0] err_b;
    logic [0:0]    fidx_b;

    logic [NC-1:0] ce_c, clr_c, d_c;
    logic [NC-1:0] q_c = '0;
    logic          busy_c, done_c, pass_c, fval_c;
    logic [EC-1:0] err_c;
    logic [0:0]    fidx_c;

    // Fault code per flop: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ignores CE.
    logic [1:0] fa [8];
    logic [1:0] fb [8];
    logic [1:0] fc [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fdce_bank_sequencer #(.N_FF(NA), .ERR_W(EA)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ff_ce(ce_a), .ff_clr(clr_a), .ff_d(d_a), .ff_q(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_idx(fidx_a), .first_err_valid(fval_a)
    );

    fdce_bank_sequencer #(.N_FF(NB), .ERR_W(EB)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ff_ce(ce_b), .ff_clr(clr_b), .ff_d(d_b), .ff_q(q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_idx(fidx_b), .first_err_valid(fval_b)
    );

    fdce_bank_sequencer #(.N_FF(NC), .ERR_W(EC)) dut_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ff_ce(ce_c), .ff_clr(clr_c), .ff_d(d_c), .ff_q(q_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .first_err_idx(fidx_c), .first_err_valid(fval_c)
    );

    function automatic logic fdce_next(input logic [1:0] f, input logic q,
                                       input logic clr, input logic ce, input logic d);
        case (f)
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            2'd3:    return clr ? 1'b0 : d;
            default: return clr ? 1'b0 : (ce ? d : q);
        endcase
    endfunction

    always @(posedge clk) for (int i = 0; i < NA; i++) q_a[i] <= fdce_next(fa[i], q_a[i], clr_a[i], ce_a[i], d_a[i]);
    always @(posedge clk) for (int i = 0; i < NB; i++) q_b[i] <= fdce_next(fb[i], q_b[i], clr_b[i], ce_b[i], d_b[i]);
    always @(posedge clk) for (int i = 0; i < NC; i++) q_c[i] <= fdce_next(fc[i], q_c[i], clr_c[i], ce_c[i], d_c[i]);

    // Each flop is read after clear (want 0), after load (want 1) and after a
    // CE-low hold (want 1). A fault gives a fixed observed triple.
    function automatic void model(input int n, input int w, input logic [1:0] f [8],
                                  output int errs, output int fidx, output bit fval);
        logic [2:0] obs;
        int         m;
        errs = 0;
        fidx = 0;
        fval = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (f[i])
                2'd1:    obs = 3'b000;
                2'd2:    obs = 3'b111;
                2'd3:    obs = 3'b010;
                default: obs = 3'b011;
            endcase
            m = $countones(obs ^ 3'b011);
            if (m > 0 && !fval) begin
                fval = 1'b1;
                fidx = i;
            end
            errs += m;
        end
        if (errs > (1 << w) - 1) errs = (1 << w) - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ideal();
        for (int i = 0; i < 8; i++) begin
            fa[i] = 2'd0;
            fb[i] = 2'd0;
            fc[i] = 2'd0;
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "/busy"}, 32'(busy_a), 32'd0);
        check({tag, "/done"}, 32'(done_a), 32'd0);
        check({tag, "/ce"},   32'(ce_a),   32'd0);
        check({tag, "/clr"},  32'(clr_a),  32'd0);
        check({tag, "/d"},    32'(d_a),    32'd0);
    endtask

    // One full pass, started by a single-cycle start pulse. The 8-flop
    // instance is checked every cycle against the timetable; all three are
    // checked at their own DONE cycle.
    task automatic run_pass(input string name, input bit glitch);
        int ea, fia, eb, fib, ec, fic;
        bit va, vb, vc;
        int flop, ph;
        logic [7:0] sel;
        model(NA, EA, fa, ea, fia, va);
        model(NB, EB, fb, eb, fib, vb);
        model(NC, EC, fc, ec, fic, vc);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 6 * NA; k++) begin
            @(negedge clk);
            start = glitch && (k == 20);
            flop = k / 6;
            ph   = k % 6;
            sel  = (k < 6 * NA) ? 8'(1 << flop) : 8'd0;
            if (k < 6 * NA) begin
                check({name, "/a_busy"}, 32'(busy_a), 32'd1);
                check({name, "/a_done"}, 32'(done_a), 32'd0);
                check({name, "/a_clr"},  32'(clr_a),  (ph == 0) ? 32'(sel) : 32'd0);
                check({name, "/a_ce"},   32'(ce_a),   (ph == 2) ? 32'(sel) : 32'd0);
                check({name, "/a_d"},    32'(d_a),    (ph == 2) ? 32'(sel) : 32'd0);
            end else begin
                check({name, "/a_done_end"}, 32'(done_a), 32'd1);
                check({name, "/a_busy_end"}, 32'(busy_a), 32'd0);
                check({name, "/a_pass"},     32'(pass_a), 32'(ea == 0));
                check({name, "/a_err"},      32'(err_a),  32'(ea));
                check({name, "/a_fval"},     32'(fval_a), 32'(va));
                if (va) check({name, "/a_fidx"}, 32'(fidx_a), 32'(fia));
            end
            if (k == 6 * NB) begin
                check({name, "/b_done"}, 32'(done_b), 32'd1);
                check({name, "/b_pass"}, 32'(pass_b), 32'(eb == 0));
                check({name, "/b_err"},  32'(err_b),  32'(eb));
                check({name, "/b_fval"}, 32'(fval_b), 32'(vb));
                if (vb) check({name, "/b_fidx"}, 32'(fidx_b), 32'(fib));
            end
            if (k == 6 * NC) begin
                check({name, "/c_done"}, 32'(done_c), 32'd1);
                check({name, "/c_pass"}, 32'(pass_c), 32'(ec == 0));
                check({name, "/c_err"},  32'(err_c),  32'(ec));
                check({name, "/c_fval"}, 32'(fval_c), 32'(vc));
            end
        end
        @(negedge clk);
        check({name, "/a_done_after"}, 32'(done_a), 32'd0);
        check({name, "/a_pass_held"},  32'(pass_a), 32'(ea == 0));
        check({name, "/a_err_held"},   32'(err_a),  32'(ea));
    endtask

    initial begin
        int  dones;
        int  v;
        bit  seen;
        int  ea, fia;
        bit  va;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_ideal();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_a("reset");
        check("reset/pass", 32'(pass_a), 32'd0);
        check("reset/err",  32'(err_a),  32'd0);
        check("reset/fval", 32'(fval_a), 32'd0);
        check("reset/fidx", 32'(fidx_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ideal bank, with a stray start mid-pass that must be ignored.
        run_pass("ideal", 1'b1);
        repeat (40) @(negedge clk);

        // Abort together with start in IDLE: nothing starts, verdict held.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start/busy", 32'(busy_a), 32'd0);
        check("abort_start/pass", 32'(pass_a), 32'd1);
        @(negedge clk);
        check("abort_start/busy2", 32'(busy_a), 32'd0);

        // Flop 3 stuck-at-0; small bank fully stuck (counter saturates).
        set_ideal();
        fa[3] = 2'd1;
        fb[0] = 2'd1;
        fb[1] = 2'd1;
        fc[0] = 2'd2;
        run_pass("stuck0", 1'b0);

        // Flop 5 ignores CE.
        set_ideal();
        fa[5] = 2'd3;
        fc[0] = 2'd3;
        run_pass("ignore_ce", 1'b0);

        // Abort at cycle 10, then a clean pass.
        set_ideal();
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_a("abort");
        check("abort/pass", 32'(pass_a), 32'd0);
        check("abort/err",  32'(err_a),  32'd0);
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("abort/no_done", 32'(dones), 32'd0);
        run_pass("after_abort", 1'b0);

        // Randomized fault mixes.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                v = $urandom_range(0, 7);
                fa[i] = (v < 5) ? 2'd0 : 2'(v - 4);
                v = $urandom_range(0, 7);
                fb[i] = (v < 5) ? 2'd0 : 2'(v - 4);
                v = $urandom_range(0, 7);
                fc[i] = (v < 5) ? 2'd0 : 2'(v - 4);
            end
            run_pass($sformatf("rand%0d", r), 1'b0);
            repeat (20) @(negedge clk);
        end

        // Reset at cycle 20 with start held high; flop 0 faulty so the
        // count is non-zero before reset.
        set_ideal();
        fa[0] = 2'd1;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) @(negedge clk);
        check("rst/err_before", 32'(err_a), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_a("rst");
        check("rst/pass", 32'(pass_a), 32'd0);
        check("rst/err",  32'(err_a),  32'd0);
        check("rst/fval", 32'(fval_a), 32'd0);
        check("rst/fidx", 32'(fidx_a), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("rst/restart_busy", 32'(busy_a), 32'd1);
        check("rst/restart_clr",  32'(clr_a),  32'd1);
        model(NA, EA, fa, ea, fia, va);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        check("rst/done_seen", 32'(seen), 32'd1);
        check("rst/pass_end",  32'(pass_a), 32'(ea == 0));
        check("rst/err_end",   32'(err_a),  32'(ea));
        check("rst/fidx_end",  32'(fidx_a), 32'(fia));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
